// File: rtl/fifo_poly_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_poly_drain                                              |
// | Description : Drains a registered-read FIFO into a valid/ready coefficient |
// |               stream with index, last-flag and polynomial counting.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_poly_drain #(
    parameter int WIDTH   = 64,
    parameter int N_COEFF = 4096,
    parameter int IDX_W   = $clog2(N_COEFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             m_last,
    output logic             poly_done,
    output logic [15:0]      poly_count
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_COEFF - 1);

    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             r_valid;
    logic [IDX_W-1:0] r_index;
    logic             r_done;
    logic [15:0]      r_count;

    logic             w_beat;
    logic [2:0]       w_credit;
    logic [2:0]       w_occ_next;
    logic             w_to_head;
    logic             w_rd;

    assign w_beat     = r_valid && m_ready;
    assign w_credit   = {1'b0, r_occ} + {2'b00, r_inflight};
    // A read may be issued into the slot that the current beat frees.
    assign w_rd       = !rst && drain_en && !fifo_empty &&
                        ((w_credit < 3'd2) || ((w_credit == 3'd2) && w_beat));
    assign w_occ_next = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_beat};
    assign w_to_head  = (r_occ == 2'd0) || ((r_occ == 2'd1) && w_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= 1'b0;
            r_index    <= '0;
            r_done     <= 1'b0;
            r_count    <= 16'd0;
        end else begin
            r_inflight <= w_rd;
            r_occ      <= w_occ_next[1:0];
            r_valid    <= (w_occ_next != 3'd0);
            if (w_beat && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end
            if (r_inflight) begin
                if (w_to_head) begin
                    r_head <= fifo_dout;
                end else begin
                    r_tail <= fifo_dout;
                end
            end
            if (w_beat) begin
                r_index <= (r_index == c_last_idx) ? '0 : r_index + IDX_W'(1);
            end
            r_done <= w_beat && m_last;
            if (w_beat && m_last) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_occ_next <= 3'd2);
        end
    end
`endif

    assign fifo_rd_en = w_rd;
    assign m_valid    = r_valid;
    assign m_data     = r_head;
    assign m_index    = r_index;
    assign m_last     = (r_index == c_last_idx);
    assign poly_done  = r_done;
    assign poly_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_poly_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_poly_drain                                           |
// | Description : Directed bench for fifo_poly_drain with a registered-read    |
// |               FIFO model, N_COEFF=4, WIDTH=16.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_poly_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        drain_en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  m_index;
    logic        m_last;
    logic        poly_done;
    logic [15:0] poly_count;
    logic        wr_en;
    logic [15:0] wr_data;

    logic [15:0] mem [0:63];
    int          wp;
    int          rp;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    fifo_poly_drain #(.WIDTH(16), .N_COEFF(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .poly_done  (poly_done),
        .poly_count (poly_count)
    );

    // Synchronous FIFO with registered read data, cleared by the same rst.
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (rst) begin
            wp        <= 0;
            rp        <= 0;
            fifo_dout <= 16'd0;
        end else begin
            if (wr_en) begin
                mem[wp % 64] <= wr_data;
                wp           <= wp + 1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= mem[rp % 64];
                rp        <= rp + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        drain_en = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
    endtask

    // Consume the stream cycle by cycle against an in-order word/index model.
    task automatic drain(input string tag, input int n, input logic [15:0] first,
                         input logic [5:0] rpat, input int plen, input int drop_at,
                         input int drop_len, input bit nobub, input int max_cyc);
        logic [15:0] exp_d;
        logic [15:0] held;
        logic [1:0]  exp_i;
        int          nb;
        int          credit;
        int          first_rd;
        int          drop_beats;
        bit          seen_v;
        bit          pend;
        bit          hold;
        exp_d = first; exp_i = 2'd0; nb = 0; credit = 0; first_rd = -1;
        drop_beats = 0; seen_v = 1'b0; pend = 1'b0; hold = 1'b0; held = 16'd0;
        for (int c = 0; c < max_cyc; c++) begin
            bit in_drop;
            bit beat;
            in_drop = (drop_at >= 0) && (c >= drop_at) && (c < drop_at + drop_len);
            chk({tag, " poly_done"}, poly_done, pend);
            if (hold) begin
                chk({tag, " hold_valid"}, m_valid, 1'b1);
                chk({tag, " hold_data"}, m_data, held);
            end
            if (m_valid && !seen_v) begin
                seen_v = 1'b1;
                chk({tag, " latency"}, c - first_rd, 2);
            end
            if (nobub && seen_v && nb < n) chk({tag, " no_bubble"}, m_valid, 1'b1);
            if (m_valid) begin
                chk({tag, " data"}, m_data, exp_d);
                chk({tag, " index"}, m_index, exp_i);
                chk({tag, " last"}, m_last, exp_i == 2'd3);
            end
            m_ready  = rpat[c % plen];
            drain_en = !in_drop;
            #1;
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (in_drop) chk({tag, " rd_in_drop"}, fifo_rd_en, 1'b0);
            beat   = m_valid && m_ready;
            credit = credit + int'(fifo_rd_en) - int'(beat);
            chk({tag, " credit_le2"}, credit <= 2, 1'b1);
            if (beat) begin
                pend  = (exp_i == 2'd3);
                exp_d = exp_d + 16'd1;
                exp_i = exp_i + 2'd1;
                nb++;
                if (in_drop) drop_beats++;
            end else begin
                pend = 1'b0;
            end
            hold = m_valid && !m_ready;
            held = m_data;
            @(negedge clk);
        end
        chk({tag, " beats"}, nb, n);
        if (drop_at >= 0) chk({tag, " drop_beats_le2"}, drop_beats <= 2, 1'b1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; drain_en = 1'b1; m_ready = 1'b1; wr_en = 1'b0; wr_data = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst m_valid", m_valid, 1'b0);
        chk("rst m_data", m_data, 16'd0);
        chk("rst m_index", m_index, 2'd0);
        chk("rst m_last", m_last, 1'b0);
        chk("rst poly_done", poly_done, 1'b0);
        chk("rst poly_count", poly_count, 16'd0);
        chk("rst rd_en", fifo_rd_en, 1'b0);
        rst = 1'b0;

        // Two polynomials back to back.
        do_reset();
        for (int i = 1; i <= 8; i++) push(16'(i));
        drain("t1", 8, 16'd1, 6'b000001, 1, -1, 0, 1'b0, 20);
        chk("t1 poly_count", poly_count, 16'd2);

        // Pre-filled FIFO, full-rate drain.
        do_reset();
        for (int i = 1; i <= 16; i++) push(16'(i));
        drain("t2", 16, 16'd1, 6'b000001, 1, -1, 0, 1'b1, 30);
        chk("t2 poly_count", poly_count, 16'd4);

        // Backpressure pattern 1,0,0,1,0,1.
        do_reset();
        for (int i = 1; i <= 10; i++) push(16'(i));
        drain("t3", 10, 16'd1, 6'b101001, 6, -1, 0, 1'b0, 40);
        chk("t3 poly_count", poly_count, 16'd2);

        // Reset with words buffered and in flight.
        drain_en = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h20 + 16'(i));
        m_ready  = 1'b0;
        drain_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 pre_rst_valid", m_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 m_valid", m_valid, 1'b0);
        chk("t6 m_index", m_index, 2'd0);
        chk("t6 poly_count", poly_count, 16'd0);
        chk("t6 poly_done", poly_done, 1'b0);
        rst = 1'b0; drain_en = 1'b0;
        push(16'h55);
        drain("t6", 1, 16'h55, 6'b000001, 1, -1, 0, 1'b0, 8);
        chk("t6 idle_after", m_valid, 1'b0);

        // Single word into an empty FIFO.
        do_reset();
        drain_en = 1'b1; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4 idle_valid", m_valid, 1'b0);
        push(16'hAB);
        drain("t4", 1, 16'hAB, 6'b000001, 1, -1, 0, 1'b0, 8);
        chk("t4 idle_after", m_valid, 1'b0);

        // drain_en dropped for 5 cycles mid-stream.
        do_reset();
        for (int i = 1; i <= 12; i++) push(16'(i));
        drain("t5", 12, 16'd1, 6'b000001, 1, 5, 5, 1'b0, 40);
        chk("t5 poly_count", poly_count, 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
